// File: rtl/phase_a_iter_if.sv
// Handshake/data bundle for phase_a_iter.
// Host side uses the master modport; the reduction block uses the slave modport.
interface phase_a_iter_if #(
  parameter int unsigned SIZE   = 3072,
  parameter int unsigned RADIX  = 54,
  parameter int unsigned STEP_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   m;
  logic [RADIX+1:0]  m_prime;
  logic [STEP_W-1:0] n_steps;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   new_a;
  logic              out_err;

  modport master (
    output in_valid, a, m, m_prime, n_steps, out_ready,
    input  in_ready, out_valid, new_a, out_err
  );

  modport slave (
    input  in_valid, a, m, m_prime, n_steps, out_ready,
    output in_ready, out_valid, new_a, out_err
  );
endinterface

// File: rtl/phase_a_iter.sv
// Iterative phase-A shift-and-reduce: new_a = (a * 2^(RADIX*n)) mod m, one Barrett-style
// step per RADIX digit, four cycles per step (EST, MULSUB, CORR1, CORR2).
// Optional build macro: PHASE_A_RANGE_CHECK_EN (operand/modulus range check, drives out_err).
module phase_a_iter #(
  parameter int unsigned SIZE      = 3072,
  parameter int unsigned RADIX     = 54,
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned STEP_W    = 7
) (
  input  logic          clk,
  input  logic          rst,
  phase_a_iter_if.slave bus_io
);

  localparam int unsigned XW  = SIZE + RADIX;  // shifted operand
  localparam int unsigned TW  = RADIX + 1;     // top slice of x used for the estimate
  localparam int unsigned MPW = RADIX + 2;     // m_prime and quotient width
  localparam int unsigned PW  = TW + MPW;      // estimate product
  localparam int unsigned QW  = XW + 2;        // q*m product
  localparam int unsigned RW  = SIZE + 2;      // partial remainder, holds [0, 3m)

  typedef enum logic [2:0] {StIdle, StEst, StMulSub, StCorr1, StCorr2, StDone} state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d, m_q, m_d;
  logic [MPW-1:0]    mp_q, mp_d, q_q, q_d;
  logic [RW-1:0]     r_q, r_d;
  logic [STEP_W-1:0] n_q, n_d, cnt_q, cnt_d;

  logic [XW-1:0]     x;
  logic [TW-1:0]     x_top;
  logic [PW-1:0]     prod;
  logic [QW-1:0]     qm;
  logic [QW-1:0]     diff;
  logic [RW-1:0]     m_ext, r_sub;
  logic              r_ge;
  logic [STEP_W-1:0] n_clamp, cnt_inc;

  assign x       = {a_q, {RADIX{1'b0}}};
  assign x_top   = x[XW-1 -: TW];
  assign prod    = {{MPW{1'b0}}, x_top} * {{TW{1'b0}}, mp_q};
  assign qm      = {{SIZE{1'b0}}, q_q} * {{MPW{1'b0}}, m_q};
  assign diff    = {2'b00, x} - qm;
  assign m_ext   = {2'b00, m_q};
  assign r_ge    = (r_q >= m_ext);
  assign r_sub   = r_q - m_ext;
  assign cnt_inc = cnt_q + STEP_W'(1);
  assign n_clamp = (bus_io.n_steps > STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS) : bus_io.n_steps;

`ifdef PHASE_A_RANGE_CHECK_EN
  logic err_q, err_d;
  logic range_bad;
  assign range_bad      = (bus_io.a >= bus_io.m) || !bus_io.m[SIZE-1];
  assign bus_io.out_err = err_q;
`else
  assign bus_io.out_err = 1'b0;
`endif

  // in_ready is forced low while reset is held, even though the FSM already sits in idle.
  assign bus_io.in_ready  = (state_q == StIdle) && !rst;
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.new_a     = a_q;

  // Next-state and datapath updates; correction cycles always run for fixed latency.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    mp_d    = mp_q;
    q_d     = q_q;
    r_d     = r_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
`ifdef PHASE_A_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.a;
          m_d     = bus_io.m;
          mp_d    = bus_io.m_prime;
          n_d     = n_clamp;
          cnt_d   = '0;
          state_d = (n_clamp == '0) ? StDone : StEst;
`ifdef PHASE_A_RANGE_CHECK_EN
          if (range_bad) begin
            a_d     = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StEst: begin
        q_d     = MPW'(prod >> TW);
        state_d = StMulSub;
      end
      StMulSub: begin
        r_d     = RW'(diff);
        state_d = StCorr1;
      end
      StCorr1: begin
        if (r_ge) r_d = r_sub;
        state_d = StCorr2;
      end
      StCorr2: begin
        a_d     = r_ge ? SIZE'(r_sub) : SIZE'(r_q);
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == n_q) ? StDone : StEst;
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
`ifdef PHASE_A_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      mp_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
`ifdef PHASE_A_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      mp_q    <= mp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
`ifdef PHASE_A_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_phase_a_iter.sv
// Directed bench for phase_a_iter at SIZE=16, RADIX=4, m=0xC001, m_prime=21.
module tb_phase_a_iter;
  localparam int unsigned SIZE      = 16;
  localparam int unsigned RADIX     = 4;
  localparam int unsigned MAX_STEPS = 64;
  localparam int unsigned STEP_W    = 7;
  localparam logic [SIZE-1:0]  M  = 16'hC001;
  localparam logic [RADIX+1:0] MP = 6'd21;
  localparam int NV = 10;

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [STEP_W-1:0] n;
    logic [SIZE-1:0]   exp_a;
    int                lat;
    logic              err;
    bit                chk_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails  = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  phase_a_iter_if #(.SIZE(SIZE), .RADIX(RADIX), .STEP_W(STEP_W)) bus ();

  phase_a_iter #(
    .SIZE(SIZE), .RADIX(RADIX), .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operand and let it be accepted; afterwards inputs are scrambled.
  task automatic issue(input logic [SIZE-1:0] a, input logic [STEP_W-1:0] n);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready before accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.m        = M;
    bus.m_prime  = MP;
    bus.n_steps  = n;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.m        = 16'h8001;
    bus.m_prime  = 6'd3;
    bus.n_steps  = 7'd9;
    check("in_ready after accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input string name, input logic [SIZE-1:0] exp_a, input int exp_lat,
                             input logic exp_err, input bit chk_data);
    int lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: out_valid=0 after %0d cycles, expected high at %0d",
               name, lat, exp_lat);
    end else begin
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      if (chk_data) check({name, " new_a"}, 32'(bus.new_a), 32'(exp_a));
      check({name, " out_err"}, 32'(bus.out_err), 32'(exp_err));
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid after handshake", 32'(bus.out_valid), 32'd0);
    check("in_ready after handshake", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.m         = M;
    bus.m_prime   = MP;
    bus.n_steps   = '0;
    bus.out_ready = 1'b0;

    // Hand-computed vectors; 0x633F -> 0x33E8 -> 0x3E7C are successive steps from 0x1234.
    vecs[0] = '{16'h1234, 7'd1,   16'h633F, 4,   1'b0, 1'b1};
    vecs[1] = '{16'h1234, 7'd2,   16'h33E8, 8,   1'b0, 1'b1};
    vecs[2] = '{16'h1234, 7'd0,   16'h1234, 0,   1'b0, 1'b1};
    vecs[3] = '{16'hC000, 7'd1,   16'hBFF1, 4,   1'b0, 1'b1};
    vecs[4] = '{16'h0000, 7'd5,   16'h0000, 20,  1'b0, 1'b1};
    vecs[5] = '{16'h633F, 7'd1,   16'h33E8, 4,   1'b0, 1'b1};
    vecs[6] = '{16'h33E8, 7'd1,   16'h3E7C, 4,   1'b0, 1'b1};
`ifdef PHASE_A_RANGE_CHECK_EN
    vecs[7] = '{16'hC001, 7'd1,   16'h0000, 0,   1'b1, 1'b1};
`else
    vecs[7] = '{16'hC001, 7'd1,   16'h0000, 4,   1'b0, 1'b0};
`endif
    vecs[8] = '{16'h1234, 7'd1,   16'h633F, 4,   1'b0, 1'b1};
    vecs[9] = '{16'h0000, 7'd127, 16'h0000, 256, 1'b0, 1'b1};

    // Reset values
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset new_a", 32'(bus.new_a), 32'd0);
    check("reset out_err", 32'(bus.out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].n);
      wait_result($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].lat, vecs[i].err,
                  vecs[i].chk_data);
      release_out();
    end

    // Back-pressure: result held for 10 cycles, in_valid pulse ignored meanwhile.
    issue(16'h1234, 7'd1);
    wait_result("hold", 16'h633F, 4, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.n_steps  = 7'd0;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d new_a", c), 32'(bus.new_a), 32'h633F);
      check($sformatf("hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    check("no queued op out_valid", 32'(bus.out_valid), 32'd0);
    check("no queued op new_a", 32'(bus.new_a), 32'h633F);

    // Reset during MULSUB of an n=3 operation.
    issue(16'h1234, 7'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort new_a", 32'(bus.new_a), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post-abort in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("no result after abort", 32'(seen), 32'd0);
    issue(16'h1234, 7'd3);
    wait_result("after abort", 16'h3E7C, 12, 1'b0, 1'b1);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
